// File: rtl/mem_master.sv
// CPU load/store to Avalon-MM master: lane steering, byte enables, load extension.
// Optional MEM_MASTER_TIMEOUT_EN aborts an access after TIMEOUT_CYCLES stalled cycles.
module mem_master #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] address,
  output logic        read,
  output logic        write,
  output logic [3:0]  byteenable,
  output logic [31:0] writedata,
  input  logic [31:0] readdata,
  input  logic        waitrequest
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t      state, state_nxt;
  logic        op_write;
  logic [1:0]  op_size;
  logic        op_signed;
  logic [1:0]  op_lane;
  logic [3:0]  op_be;
  logic        accept, req_bad, access_end, timed_out;
  logic [3:0]  be_calc;
  logic [31:0] wdata_calc;

  assign req_ready  = (state == IDLE);
  assign accept     = req_valid & req_ready;
  assign resp_valid = (state == DONE);
  assign read       = (state == ACCESS) & ~op_write;
  assign write      = (state == ACCESS) & op_write;
  assign byteenable = (state == ACCESS) ? op_be : 4'b0000;

  assign req_bad = (req_size == 2'b11)
                 | ((req_size == 2'b01) & req_addr[0])
                 | ((req_size == 2'b10) & (req_addr[1:0] != 2'b00));

  // NOTE: every signal written in always_comb gets a default first, so no path infers a latch.
  always_comb begin
    be_calc    = 4'b0000;
    wdata_calc = req_wdata;
    case (req_size)
      2'b00: begin
        be_calc    = 4'b0001 << req_addr[1:0];
        wdata_calc = {4{req_wdata[7:0]}};
      end
      2'b01: begin
        be_calc    = req_addr[1] ? 4'b1100 : 4'b0011;
        wdata_calc = {2{req_wdata[15:0]}};
      end
      2'b10:   be_calc = 4'b1111;
      default: be_calc = 4'b0000;
    endcase
  end

  function automatic logic [31:0] load_extract(input logic [31:0] data, input logic [1:0] size,
                                               input logic [1:0] lane, input logic sgn);
    logic [31:0] shifted;
    shifted = data >> {lane, 3'b000};
    case (size)
      2'b00:   return {{24{sgn & shifted[7]}}, shifted[7:0]};
      2'b01:   return {{16{sgn & shifted[15]}}, shifted[15:0]};
      default: return data;
    endcase
  endfunction

`ifdef MEM_MASTER_TIMEOUT_EN
  localparam int CW = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
  logic [CW-1:0] stall_cnt;

  // Abort on the edge whose stalled cycle brings the count up to TIMEOUT_CYCLES.
  assign timed_out = waitrequest && (stall_cnt == CW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      stall_cnt <= '0;
    else if (state != ACCESS)
      stall_cnt <= '0;
    else if (waitrequest)
      stall_cnt <= stall_cnt + 1'b1;
  end
`else
  assign timed_out = 1'b0;
`endif

  assign access_end = (state == ACCESS) && (!waitrequest || timed_out);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = req_bad ? DONE : ACCESS;
      ACCESS:  if (access_end) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_write   <= 1'b0;
      op_size    <= 2'b00;
      op_signed  <= 1'b0;
      op_lane    <= 2'b00;
      op_be      <= 4'b0000;
      address    <= '0;
      writedata  <= '0;
      resp_err   <= 1'b0;
      resp_rdata <= '0;
    end else if (accept) begin
      op_write   <= req_write;
      op_size    <= req_size;
      op_signed  <= req_signed;
      op_lane    <= req_addr[1:0];
      op_be      <= be_calc;
      address    <= {req_addr[31:2], 2'b00};
      writedata  <= wdata_calc;
      resp_err   <= req_bad;
      resp_rdata <= '0;
    end else if (access_end) begin
      resp_err   <= timed_out;
      resp_rdata <= (op_write || timed_out) ? 32'h0
                  : load_extract(readdata, op_size, op_lane, op_signed);
    end
  end

endmodule
